// File: rtl/fft_r22sdf_bf_stage_if.sv
// rtl/fft_r22sdf_bf_stage_if.sv - sample-in / spectrum-out bus of one R2^2 SDF stage
interface fft_r22sdf_bf_stage_if #(
    parameter int DW = 25
);
    logic                 valid_i;
    logic signed [DW-1:0] x_re_i;
    logic signed [DW-1:0] x_im_i;
    logic                 valid_o;
    logic                 frame_o;
    logic signed [DW+1:0] z_re_o;
    logic signed [DW+1:0] z_im_o;

    modport slave (
        input  valid_i, x_re_i, x_im_i,
        output valid_o, frame_o, z_re_o, z_im_o
    );

    modport master (
        output valid_i, x_re_i, x_im_i,
        input  valid_o, frame_o, z_re_o, z_im_o
    );
endinterface

// File: rtl/fft_r22sdf_bf_stage.sv
// rtl/fft_r22sdf_bf_stage.sv - radix-2^2 SDF stage (BF-I, -j rotator, BF-II); FFT_R22SDF_OREG_EN registers outputs
module fft_r22sdf_bf_stage #(
    parameter int DW     = 25,
    parameter int LOG2_L = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    fft_r22sdf_bf_stage_if.slave  bus
);
    localparam int L  = 1 << LOG2_L;
    localparam int CW = LOG2_L + 2;
    localparam int W1 = DW + 1;
    localparam int W2 = DW + 2;

    logic [CW-1:0] c_q, c_d;
    logic [CW-1:0] fill_q, fill_d;

    logic signed [W1-1:0] sr1_re_q [2*L];
    logic signed [W1-1:0] sr1_im_q [2*L];
    logic signed [W1-1:0] sr1_re_d [2*L];
    logic signed [W1-1:0] sr1_im_d [2*L];
    logic signed [W2-1:0] sr2_re_q [L];
    logic signed [W2-1:0] sr2_im_q [L];
    logic signed [W2-1:0] sr2_re_d [L];
    logic signed [W2-1:0] sr2_im_d [L];

    logic                 sel1, sel2, fill_done;
    logic signed [W1-1:0] x_re, x_im, y_re, y_im, fb1_re, fb1_im, r_re, r_im;
    logic signed [W2-1:0] u_re, u_im, z_re, z_im, fb2_re, fb2_im;

    logic                 valid_o_d, frame_o_d;
    logic signed [W2-1:0] z_re_o_d, z_im_o_d;

    always_comb begin
        sel1      = c_q[CW-1];
        sel2      = c_q[CW-2];
        fill_done = (fill_q == CW'(3 * L));
        x_re      = {bus.x_re_i[DW-1], bus.x_re_i};
        x_im      = {bus.x_im_i[DW-1], bus.x_im_i};

        if (sel1) begin
            y_re   = x_re + sr1_re_q[2*L-1];
            y_im   = x_im + sr1_im_q[2*L-1];
            fb1_re = sr1_re_q[2*L-1] - x_re;
            fb1_im = sr1_im_q[2*L-1] - x_im;
        end else begin
            y_re   = sr1_re_q[2*L-1];
            y_im   = sr1_im_q[2*L-1];
            fb1_re = x_re;
            fb1_im = x_im;
        end

        // Second-half BF-I differences coming out of the feedback loop get -j
        if (!sel1 && sel2) begin
            r_re = y_im;
            r_im = -y_re;
        end else begin
            r_re = y_re;
            r_im = y_im;
        end

        u_re = {r_re[W1-1], r_re};
        u_im = {r_im[W1-1], r_im};
        if (sel2) begin
            z_re   = u_re + sr2_re_q[L-1];
            z_im   = u_im + sr2_im_q[L-1];
            fb2_re = sr2_re_q[L-1] - u_re;
            fb2_im = sr2_im_q[L-1] - u_im;
        end else begin
            z_re   = sr2_re_q[L-1];
            z_im   = sr2_im_q[L-1];
            fb2_re = u_re;
            fb2_im = u_im;
        end

        c_d      = c_q;
        fill_d   = fill_q;
        sr1_re_d = sr1_re_q;
        sr1_im_d = sr1_im_q;
        sr2_re_d = sr2_re_q;
        sr2_im_d = sr2_im_q;
        if (bus.valid_i) begin
            c_d = c_q + CW'(1);
            if (!fill_done) begin
                fill_d = fill_q + CW'(1);
            end
            sr1_re_d[0] = fb1_re;
            sr1_im_d[0] = fb1_im;
            for (int i = 1; i < 2 * L; i++) begin
                sr1_re_d[i] = sr1_re_q[i-1];
                sr1_im_d[i] = sr1_im_q[i-1];
            end
            sr2_re_d[0] = fb2_re;
            sr2_im_d[0] = fb2_im;
            for (int i = 1; i < L; i++) begin
                sr2_re_d[i] = sr2_re_q[i-1];
                sr2_im_d[i] = sr2_im_q[i-1];
            end
        end

        valid_o_d = bus.valid_i && fill_done;
        frame_o_d = valid_o_d && (c_q == CW'(3 * L));
        z_re_o_d  = valid_o_d ? z_re : '0;
        z_im_o_d  = valid_o_d ? z_im : '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            c_q    <= '0;
            fill_q <= '0;
            for (int i = 0; i < 2 * L; i++) begin
                sr1_re_q[i] <= '0;
                sr1_im_q[i] <= '0;
            end
            for (int i = 0; i < L; i++) begin
                sr2_re_q[i] <= '0;
                sr2_im_q[i] <= '0;
            end
        end else begin
            c_q      <= c_d;
            fill_q   <= fill_d;
            sr1_re_q <= sr1_re_d;
            sr1_im_q <= sr1_im_d;
            sr2_re_q <= sr2_re_d;
            sr2_im_q <= sr2_im_d;
        end
    end

`ifdef FFT_R22SDF_OREG_EN
    logic                 valid_o_q, frame_o_q;
    logic signed [W2-1:0] z_re_o_q, z_im_o_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            valid_o_q <= 1'b0;
            frame_o_q <= 1'b0;
            z_re_o_q  <= '0;
            z_im_o_q  <= '0;
        end else begin
            valid_o_q <= valid_o_d;
            frame_o_q <= frame_o_d;
            z_re_o_q  <= z_re_o_d;
            z_im_o_q  <= z_im_o_d;
        end
    end

    assign bus.valid_o = valid_o_q;
    assign bus.frame_o = frame_o_q;
    assign bus.z_re_o  = z_re_o_q;
    assign bus.z_im_o  = z_im_o_q;
`else
    assign bus.valid_o = valid_o_d;
    assign bus.frame_o = frame_o_d;
    assign bus.z_re_o  = z_re_o_d;
    assign bus.z_im_o  = z_im_o_d;
`endif
endmodule

// File: tb/tb_fft_r22sdf_bf_stage.sv
// tb/tb_fft_r22sdf_bf_stage.sv - bench for fft_r22sdf_bf_stage at L=1, L=4 and L=2
module tb_fft_r22sdf_bf_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_r22sdf_bf_stage_if #(.DW(8))  if_a ();
    fft_r22sdf_bf_stage_if #(.DW(12)) if_b ();
    fft_r22sdf_bf_stage_if #(.DW(8))  if_c ();

    fft_r22sdf_bf_stage #(.DW(8),  .LOG2_L(0)) dut_a (.clk_i(clk), .rst_n(rst_n), .bus(if_a));
    fft_r22sdf_bf_stage #(.DW(12), .LOG2_L(2)) dut_b (.clk_i(clk), .rst_n(rst_n), .bus(if_b));
    fft_r22sdf_bf_stage #(.DW(8),  .LOG2_L(1)) dut_c (.clk_i(clk), .rst_n(rst_n), .bus(if_c));

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    int ll [3] = '{1, 4, 2};
    int xr [3][0:1023];
    int xi [3][0:1023];
    int cnt [3] = '{0, 0, 0};

    bit cur_v [3], cur_f [3], prv_v [3], prv_f [3], chk_v [3], chk_f [3];
    int cur_re [3], cur_im [3], prv_re [3], prv_im [3], chk_re [3], chk_im [3];

    int cap_re [3][16];
    int cap_im [3][16];
    int cap_f  [3][16];
    int cap_n  [3] = '{0, 0, 0};
    int vcnt   [3] = '{0, 0, 0};

    // Output k of a stage is the 4-point DFT over x[n], x[n+L], x[n+2L], x[n+3L]
    // of its frame, bins emitted in order 0,2,1,3 and each bin spanning L samples.
    function automatic void model_exp(input int j, input int i, output int er, output int ei);
        int l, k, f, t, b, n, kk, r, im;
        l = ll[j];
        k = i - 3 * l;
        f = k / (4 * l);
        t = k % (4 * l);
        b = t / l;
        n = t % l;
        kk = (b == 1) ? 2 : (b == 2) ? 1 : b;
        er = 0;
        ei = 0;
        for (int m = 0; m < 4; m++) begin
            r  = xr[j][f * 4 * l + n + m * l];
            im = xi[j][f * 4 * l + n + m * l];
            case ((m * kk) % 4)
                0: begin er += r;   ei += im; end
                1: begin er += im;  ei -= r;  end
                2: begin er -= r;   ei -= im; end
                default: begin er -= im; ei += r; end
            endcase
        end
    endfunction

    task automatic advance(input int j, input bit v, input int re, input int im, input bit rst);
        @(posedge clk);
        #1;
        rst_n = !rst;
        if_a.valid_i = !rst && v && (j == 0);
        if_b.valid_i = !rst && v && (j == 1);
        if_c.valid_i = !rst && v && (j == 2);
        if_a.x_re_i = 8'(re);  if_a.x_im_i = 8'(im);
        if_b.x_re_i = 12'(re); if_b.x_im_i = 12'(im);
        if_c.x_re_i = 8'(re);  if_c.x_im_i = 8'(im);
        for (int jj = 0; jj < 3; jj++) begin
            cur_v[jj] = 1'b0; cur_f[jj] = 1'b0; cur_re[jj] = 0; cur_im[jj] = 0;
            if (rst) begin
                cnt[jj] = 0;
            end else if (v && jj == j) begin
                int i;
                i = cnt[jj];
                xr[jj][i] = re;
                xi[jj][i] = im;
                cnt[jj] = i + 1;
                if (i >= 3 * ll[jj]) begin
                    cur_v[jj] = 1'b1;
                    cur_f[jj] = ((i % (4 * ll[jj])) == 3 * ll[jj]);
                    model_exp(jj, i, cur_re[jj], cur_im[jj]);
                end
            end
        end
`ifdef FFT_R22SDF_OREG_EN
        chk_v = prv_v; chk_f = prv_f; chk_re = prv_re; chk_im = prv_im;
        prv_v = cur_v; prv_f = cur_f; prv_re = cur_re; prv_im = cur_im;
`else
        chk_v = cur_v; chk_f = cur_f; chk_re = cur_re; chk_im = cur_im;
`endif
    endtask

    task automatic check(input int j, input logic v, input logic f, input int re, input int im);
        checks += 4;
        if (v !== chk_v[j]) begin
            failures++;
            $display("FAIL valid_o inst%0d at %0t: actual %b required %b", j, $time, v, chk_v[j]);
        end
        if (f !== chk_f[j]) begin
            failures++;
            $display("FAIL frame_o inst%0d at %0t: actual %b required %b", j, $time, f, chk_f[j]);
        end
        if (re != chk_re[j]) begin
            failures++;
            $display("FAIL z_re_o inst%0d at %0t: actual %0d required %0d", j, $time, re, chk_re[j]);
        end
        if (im != chk_im[j]) begin
            failures++;
            $display("FAIL z_im_o inst%0d at %0t: actual %0d required %0d", j, $time, im, chk_im[j]);
        end
        if (v === 1'b1) begin
            vcnt[j]++;
            if (cap_n[j] < 16) begin
                cap_re[j][cap_n[j]] = re;
                cap_im[j][cap_n[j]] = im;
                cap_f[j][cap_n[j]]  = int'(f);
                cap_n[j]++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check(0, if_a.valid_o, if_a.frame_o, int'(if_a.z_re_o), int'(if_a.z_im_o));
            check(1, if_b.valid_o, if_b.frame_o, int'(if_b.z_re_o), int'(if_b.z_im_o));
            check(2, if_c.valid_o, if_c.frame_o, int'(if_c.z_re_o), int'(if_c.z_im_o));
        end
    end

    task automatic lit(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual %0d required %0d", nm, act, req);
        end
    endtask

    task automatic clear_caps();
        for (int j = 0; j < 3; j++) begin
            cap_n[j] = 0;
            vcnt[j]  = 0;
        end
    endtask

    initial begin
        int t1_in [8] = '{1, 2, 3, 4, 0, 0, 0, 0};
        int t1_re [4] = '{10, -2, -2, -2};
        int t1_im [4] = '{0, 0, 2, -2};
        int t1_fr [5] = '{1, 0, 0, 0, 1};
        int sent;
        bit v;
        for (int j = 0; j < 3; j++) begin
            prv_v[j] = 1'b0; prv_f[j] = 1'b0; prv_re[j] = 0; prv_im[j] = 0;
        end
        if_a.valid_i = 1'b0; if_b.valid_i = 1'b0; if_c.valid_i = 1'b0;
        if_a.x_re_i = '0; if_a.x_im_i = '0;
        if_b.x_re_i = '0; if_b.x_im_i = '0;
        if_c.x_re_i = '0; if_c.x_im_i = '0;

        repeat (2) advance(0, 1'b0, 0, 0, 1'b1);
        chk_en = 1'b1;
        advance(0, 1'b0, 0, 0, 1'b1);

        // 1,2,3,4 on the L=1 stage
        clear_caps();
        foreach (t1_in[i]) advance(0, 1'b1, t1_in[i], 0, 1'b0);
        repeat (2) advance(0, 1'b0, 0, 0, 1'b0);
        lit("t1_count", cap_n[0], 5);
        for (int i = 0; i < 4; i++) begin
            lit($sformatf("t1_re%0d", i), cap_re[0][i], t1_re[i]);
            lit($sformatf("t1_im%0d", i), cap_im[0][i], t1_im[i]);
        end
        for (int i = 0; i < 5; i++) lit($sformatf("t1_frame%0d", i), cap_f[0][i], t1_fr[i]);

        // Most negative constant input: DC bin at full scale, rest zero
        repeat (2) advance(0, 1'b0, 0, 0, 1'b1);
        clear_caps();
        repeat (12) advance(0, 1'b1, -128, -128, 1'b0);
        repeat (2) advance(0, 1'b0, 0, 0, 1'b0);
        lit("t2_count", cap_n[0], 9);
        for (int i = 0; i < 8; i++) begin
            lit($sformatf("t2_re%0d", i), cap_re[0][i], (i % 4 == 0) ? -512 : 0);
            lit($sformatf("t2_im%0d", i), cap_im[0][i], (i % 4 == 0) ? -512 : 0);
        end

        // Random frames on the L=4 stage with random input gaps
        clear_caps();
        sent = 0;
        while (sent < 96) begin
            v = 1'($urandom_range(0, 1));
            advance(1, v, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048, 1'b0);
            if (v) sent++;
        end
        repeat (2) advance(1, 1'b0, 0, 0, 1'b0);
        lit("t3_outputs", vcnt[1], 84);

        // Reset mid-frame, then a fresh stream
        repeat (2) advance(1, 1'b0, 0, 0, 1'b1);
        clear_caps();
        repeat (7) advance(1, 1'b1, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048, 1'b0);
        repeat (2) advance(1, 1'b0, 0, 0, 1'b1);
        lit("t4_pre_reset", vcnt[1], 0);
        repeat (12) advance(1, 1'b1, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048, 1'b0);
        advance(1, 1'b0, 0, 0, 1'b0);
        lit("t4_fill", vcnt[1], 0);
        repeat (36) advance(1, 1'b1, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048, 1'b0);
        repeat (2) advance(1, 1'b0, 0, 0, 1'b0);
        lit("t4_outputs", vcnt[1], 36);

        // Impulse on the L=2 stage: x[0] feeds every bin at n=0, nothing at n=1
        clear_caps();
        advance(2, 1'b1, 1, 0, 1'b0);
        repeat (13) advance(2, 1'b1, 0, 0, 1'b0);
        repeat (2) advance(2, 1'b0, 0, 0, 1'b0);
        lit("t5_count", cap_n[2], 8);
        for (int i = 0; i < 8; i++) begin
            lit($sformatf("t5_re%0d", i), cap_re[2][i], (i % 2 == 0) ? 1 : 0);
            lit($sformatf("t5_im%0d", i), cap_im[2][i], 0);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
